// File: rtl/bram2rgb_scaler.sv
// Frame-buffer reader: 320x180 RGB888 BRAM image -> 1280x720@60 video with 4x pixel/line replication.
// Optional colour-bar generator is built in when TEST_PATTERN_EN is defined.
module bram2rgb_scaler #(
  parameter int H_ACTIVE    = 1280,
  parameter int H_FP        = 110,
  parameter int H_SYNC      = 40,
  parameter int H_BP        = 220,
  parameter int V_ACTIVE    = 720,
  parameter int V_FP        = 5,
  parameter int V_SYNC      = 5,
  parameter int V_BP        = 20,
  parameter int HS_POL      = 1,
  parameter int VS_POL      = 1,
  parameter int SRC_W       = 320,
  parameter int SCALE_SHIFT = 2,
  parameter int RD_LAT      = 2
) (
  input  logic        pclk,
  input  logic        rstb,
  input  logic        enable,
`ifdef TEST_PATTERN_EN
  input  logic        pattern_sel,
`endif
  output logic        bram_en,
  output logic [15:0] bram_addr,
  input  logic [23:0] bram_rdata,
  output logic [23:0] vid_pData,
  output logic        vid_pVDE,
  output logic        vid_pHSync,
  output logic        vid_pVSync,
  output logic        frame_start,
  output logic        running
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] HS_BEG     = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG     = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] LINE_MASK  = VW'((1 << SCALE_SHIFT) - 1);
  localparam logic [15:0]   SRC_STEP   = 16'(SRC_W);
  localparam logic          HS_ON      = 1'(HS_POL);
  localparam logic          VS_ON      = 1'(VS_POL);
`ifdef TEST_PATTERN_EN
  localparam int FW    = 8;
  localparam int BAR_W = H_ACTIVE / 8;
`else
  localparam int FW    = 4;
`endif

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic [15:0]   line_base;
  logic          run, h_last, v_last, frame_wrap;

  assign run        = (state == RUN);
  assign running    = run;
  assign h_last     = (hcnt == H_LAST);
  assign v_last     = (vcnt == V_LAST);
  assign frame_wrap = h_last && v_last;

`ifdef TEST_PATTERN_EN
  logic pat_q;

  function automatic logic [2:0] bar_idx(input logic [HW-1:0] h);
    logic [2:0] idx;
    idx = 3'd0;
    for (int k = 1; k < 8; k++)
      if (h >= HW'(k * BAR_W)) idx = 3'(k);
    return idx;
  endfunction

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return 24'hFFFFFF;
      3'd1:    return 24'hFFFF00;
      3'd2:    return 24'h00FFFF;
      3'd3:    return 24'h00FF00;
      3'd4:    return 24'hFF00FF;
      3'd5:    return 24'hFF0000;
      3'd6:    return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Pattern choice only changes on a frame boundary so a frame is never mixed.
  always_ff @(posedge pclk or negedge rstb) begin
    if (!rstb)                  pat_q <= 1'b0;
    else if (!run || frame_wrap) pat_q <= pattern_sel;
  end
`endif

  always_ff @(posedge pclk or negedge rstb) begin
    if (!rstb) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (enable) state_nx = RUN;
      RUN:     if (frame_wrap && !enable) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge rstb) begin
    if (!rstb || 1'b0) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (!run) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (h_last) begin
      hcnt <= '0;
      vcnt <= v_last ? '0 : vcnt + 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  // Source line offset advances after the last replicated copy of each source line.
  always_ff @(posedge pclk or negedge rstb) begin
    if (!rstb)
      line_base <= '0;
    else if (!run || frame_wrap)
      line_base <= '0;
    else if (hcnt == H_ACT_LAST && vcnt < V_ACT_END && (vcnt & LINE_MASK) == LINE_MASK)
      line_base <= line_base + SRC_STEP;
  end

  // Stage 0: timing decode from the counters
  logic          act_p0, hs_p0, vs_p0, fs_p0;
  logic [FW-1:0] flg_p0;

  assign act_p0 = run && (hcnt < H_ACT_END) && (vcnt < V_ACT_END);
  assign hs_p0  = run && (hcnt >= HS_BEG) && (hcnt < HS_END);
  assign vs_p0  = run && (vcnt >= VS_BEG) && (vcnt < VS_END);
  assign fs_p0  = run && (hcnt == '0) && (vcnt == '0);
`ifdef TEST_PATTERN_EN
  assign flg_p0 = {bar_idx(hcnt), pat_q, fs_p0, vs_p0, hs_p0, act_p0};
`else
  assign flg_p0 = {fs_p0, vs_p0, hs_p0, act_p0};
`endif

  // Stage 1..1+RD_LAT: BRAM request, flags ride alongside the read latency
  logic [FW-1:0] dly_p1 [0:RD_LAT];

  always_ff @(posedge pclk or negedge rstb) begin
    if (!rstb) begin
      bram_en   <= 1'b0;
      bram_addr <= '0;
      for (int i = 0; i <= RD_LAT; i++) dly_p1[i] <= '0;
    end else if (!run) begin
      bram_en   <= 1'b0;
      bram_addr <= '0;
      for (int i = 0; i <= RD_LAT; i++) dly_p1[i] <= '0;
    end else begin
`ifdef TEST_PATTERN_EN
      bram_en   <= act_p0 && !pat_q;
`else
      bram_en   <= act_p0;
`endif
      bram_addr <= act_p0 ? line_base + 16'(hcnt >> SCALE_SHIFT) : 16'd0;
      dly_p1[0] <= flg_p0;
      for (int i = 1; i <= RD_LAT; i++) dly_p1[i] <= dly_p1[i-1];
    end
  end

  // Output stage: flags meet the returning BRAM word
  logic [FW-1:0] flg_o;
  logic [23:0]   pix_o;

  assign flg_o = dly_p1[RD_LAT];
`ifdef TEST_PATTERN_EN
  assign pix_o = !flg_o[0] ? 24'h0 : (flg_o[4] ? bar_colour(flg_o[7:5]) : bram_rdata);
`else
  assign pix_o = flg_o[0] ? bram_rdata : 24'h0;
`endif

  always_ff @(posedge pclk or negedge rstb) begin
    if (!rstb) begin
      vid_pData   <= '0;
      vid_pVDE    <= 1'b0;
      vid_pHSync  <= ~HS_ON;
      vid_pVSync  <= ~VS_ON;
      frame_start <= 1'b0;
    end else begin
      vid_pData   <= pix_o;
      vid_pVDE    <= flg_o[0];
      vid_pHSync  <= flg_o[1] ~^ HS_ON;
      vid_pVSync  <= flg_o[2] ~^ VS_ON;
      frame_start <= flg_o[3];
    end
  end
endmodule

// File: tb/tb_bram2rgb_scaler.sv
// Bench for bram2rgb_scaler: three instances (RD_LAT 1, 2, 4) on a reduced raster, checked every cycle
// against a position-based model of the video timeline and a BRAM that returns its address.
module tb_bram2rgb_scaler;
  localparam int HA = 32, HFP = 4, HSW = 3, HBP = 5;
  localparam int VA = 16, VFP = 2, VSW = 2, VBP = 3;
  localparam int SW = 8, SCALE = 4;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;
  localparam int NI = 3;

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 2 : 4;
  endfunction

  logic pclk = 1'b0, rstb = 1'b0, enable = 1'b0;
  logic        en_a [NI];
  logic [15:0] addr_a [NI];
  logic [23:0] rdata_a [NI];
  logic [23:0] data_a [NI];
  logic        vde_a [NI], hs_a [NI], vs_a [NI], fs_a [NI], run_a [NI];

  always #5 pclk = ~pclk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int L = lat_of(g);
    logic [23:0] rd_pipe [L];

    bram2rgb_scaler #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
      .HS_POL(1), .VS_POL(1), .SRC_W(SW), .SCALE_SHIFT(2), .RD_LAT(L)
    ) u_dut (
      .pclk(pclk), .rstb(rstb), .enable(enable),
      .bram_en(en_a[g]), .bram_addr(addr_a[g]), .bram_rdata(rdata_a[g]),
      .vid_pData(data_a[g]), .vid_pVDE(vde_a[g]), .vid_pHSync(hs_a[g]),
      .vid_pVSync(vs_a[g]), .frame_start(fs_a[g]), .running(run_a[g])
    );

    always @(posedge pclk) begin
      if (en_a[g]) rd_pipe[0] <= {8'h00, addr_a[g]};
      for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign rdata_a[g] = rd_pipe[L-1];
  end

  // Model: raster position of the generator for each of the last 8 cycles
  typedef struct { bit run; int x; int y; } pos_t;
  pos_t hist [8];
  bit   m_run = 1'b0;
  int   m_h = 0, m_v = 0, cyc = 0;

  always @(posedge pclk or negedge rstb) begin
    if (!rstb) begin
      m_run = 1'b0; m_h = 0; m_v = 0;
      for (int i = 0; i < 8; i++) hist[i] = '{1'b0, 0, 0};
    end else begin
      if (!m_run) begin
        m_run = enable; m_h = 0; m_v = 0;
      end else if (m_h == HT - 1) begin
        m_h = 0;
        if (m_v == VT - 1) begin m_v = 0; m_run = enable; end
        else m_v++;
      end else begin
        m_h++;
      end
      cyc++;
      hist[3'(cyc)] = '{m_run, m_h, m_v};
    end
  end

  function automatic bit e_act(input pos_t p);
    return p.run && p.x < HA && p.y < VA;
  endfunction
  function automatic bit e_hs(input pos_t p);
    return p.run && p.x >= HA + HFP && p.x < HA + HFP + HSW;
  endfunction
  function automatic bit e_vs(input pos_t p);
    return p.run && p.y >= VA + VFP && p.y < VA + VFP + VSW;
  endfunction
  function automatic bit e_fs(input pos_t p);
    return p.run && p.x == 0 && p.y == 0;
  endfunction
  function automatic logic [15:0] e_addr(input pos_t p);
    return e_act(p) ? 16'((p.y / SCALE) * SW + p.x / SCALE) : 16'd0;
  endfunction

  int errors = 0, checks = 0, shown = 0;
  int fs_cnt [NI];
  bit fs_req = 1'b0, to_pending = 1'b0, to_seen = 1'b0;

  task automatic chk(input string name, input int i, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (shown < 40) begin
        shown++;
        $display("FAIL %s lat=%0d cyc=%0d got=%0h want=%0h", name, lat_of(i), cyc, got, exp);
      end
    end
  endtask

  pos_t p, q;
  int   lat;
  always @(negedge pclk) begin
    for (int i = 0; i < NI; i++) begin
      lat = lat_of(i);
      p = hist[3'(cyc - 2 - lat)];
      q = hist[3'(cyc - 1)];
      if (fs_a[i]) fs_cnt[i]++;
      chk("sync", i, {59'd0, vde_a[i], hs_a[i], vs_a[i], fs_a[i], run_a[i]},
          {59'd0, e_act(p), e_hs(p), e_vs(p), e_fs(p), m_run});
      chk("bram", i, {47'd0, en_a[i], addr_a[i]}, {47'd0, e_act(q), e_addr(q)});
      chk("pixel", i, {40'd0, data_a[i]}, {40'd0, 8'd0, e_addr(p)});
      if (p.run && p.x == 5 && p.y == 9)
        chk("pix_5_9", i, {40'd0, data_a[i]}, 64'd17);
      if (p.run && p.x == HA - 1 && p.y == VA - 1)
        chk("pix_last", i, {40'd0, data_a[i]}, 64'd31);
      if (p.run && p.x < 4 && p.y < 4)
        chk("pix_first_block", i, {39'd0, vde_a[i], data_a[i]}, 64'h100_0000);
      if (!rstb)
        chk("reset_values", i, {18'd0, vde_a[i], hs_a[i], vs_a[i], fs_a[i], run_a[i],
            en_a[i], addr_a[i], data_a[i]}, 64'd0);
      if (fs_req)
        chk("frame_start_count", i, 64'(fs_cnt[i]), 64'd2);
    end
    if (to_pending && !to_seen) begin
      to_seen = 1'b1;
      chk("wait_bound", 0, 64'd1, 64'd0);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge pclk); #3; end
  endtask

  task automatic wait_pos(input int h, input int v);
    int n = 0;
    while (!(m_run && m_h == h && m_v == v) && n < 3 * FRAME) begin tick(1); n++; end
    if (n >= 3 * FRAME) to_pending = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_run && n < 3 * FRAME) begin tick(1); n++; end
    if (n >= 3 * FRAME) to_pending = 1'b1;
  endtask

  initial begin
    tick(5);
    rstb = 1'b1;
    tick(500);
    enable = 1'b1;
    tick(2 * FRAME - 10);
    fs_req = 1'b1;
    tick(1);
    fs_req = 1'b0;
    // Stop request mid-frame completes the frame, then idles
    wait_pos(0, 10);
    enable = 1'b0;
    wait_idle();
    tick(60);
    enable = 1'b1;
    // Stop request withdrawn before the wrap keeps running
    wait_pos(0, 8);
    enable = 1'b0;
    wait_pos(0, 12);
    enable = 1'b1;
    wait_pos(0, 3);
    // Asynchronous reset in the middle of an active line
    wait_pos(20, 6);
    rstb = 1'b0;
    tick(3);
    rstb = 1'b1;
    tick(FRAME + 50);
    for (int k = 0; k < 8; k++) begin
      enable = 1'($urandom_range(0, 1));
      tick($urandom_range(100, 1500));
    end
    enable = 1'b0;
    wait_idle();
    tick(20);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
